// File: rtl/uv_apb_initiator_if.sv
//------------------------------------------------------------------------------
// Module      : uv_apb_initiator_if
// Description : Request/response and APB4 signal bundle for uv_apb_initiator.
//               The master modport is the initiator's view; the slave modport
//               is the requester + APB responder view.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uv_apb_initiator_if #(
    parameter int ALEN = 12,
    parameter int DLEN = 32,
    parameter int MLEN = DLEN / 8
);
    // Requester side
    logic            req_vld;
    logic            req_rdy;
    logic            req_read;
    logic [ALEN-1:0] req_addr;
    logic [MLEN-1:0] req_mask;
    logic [DLEN-1:0] req_data;
    logic [2:0]      req_prot;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic            rsp_excp;
    logic [DLEN-1:0] rsp_data;

    // APB side
    logic            apb_psel;
    logic            apb_penable;
    logic [2:0]      apb_pprot;
    logic [ALEN-1:0] apb_paddr;
    logic [MLEN-1:0] apb_pstrb;
    logic            apb_pwrite;
    logic [DLEN-1:0] apb_pwdata;
    logic [DLEN-1:0] apb_prdata;
    logic            apb_pready;
    logic            apb_pslverr;

    modport master (
        input  req_vld, req_read, req_addr, req_mask, req_data, req_prot,
        input  rsp_rdy, apb_prdata, apb_pready, apb_pslverr,
        output req_rdy, rsp_vld, rsp_excp, rsp_data,
        output apb_psel, apb_penable, apb_pprot, apb_paddr, apb_pstrb,
        output apb_pwrite, apb_pwdata
    );

    modport slave (
        output req_vld, req_read, req_addr, req_mask, req_data, req_prot,
        output rsp_rdy, apb_prdata, apb_pready, apb_pslverr,
        input  req_rdy, rsp_vld, rsp_excp, rsp_data,
        input  apb_psel, apb_penable, apb_pprot, apb_paddr, apb_pstrb,
        input  apb_pwrite, apb_pwdata
    );
endinterface

`default_nettype wire

// File: rtl/uv_apb_initiator.sv
//------------------------------------------------------------------------------
// Module      : uv_apb_initiator
// Description : Single-outstanding valid/ready to APB4 bridge with setup/access
//               sequencing, wait-state handling and access-phase timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uv_apb_initiator #(
    parameter int ALEN    = 12,
    parameter int DLEN    = 32,
    parameter int MLEN    = DLEN / 8,
    parameter int TMO_CYC = 256
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    uv_apb_initiator_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Counter is wide enough to hold TMO_CYC; a disabled timeout still keeps
    // a 1-bit counter so the datapath stays uniform.
    localparam int              CNT_W    = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam bit              TMO_EN   = (TMO_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TMO_CYC > 0) ? CNT_W'(TMO_CYC - 1) : '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_rdy_q, req_rdy_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic              rsp_excp_q, rsp_excp_d;
    logic [DLEN-1:0]   rsp_data_q, rsp_data_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [2:0]        pprot_q, pprot_d;
    logic [ALEN-1:0]   paddr_q, paddr_d;
    logic [MLEN-1:0]   pstrb_q, pstrb_d;
    logic              pwrite_q, pwrite_d;
    logic [DLEN-1:0]   pwdata_q, pwdata_d;

    // Next-state, capture and registered-output decode for the transfer FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_excp_d = rsp_excp_q;
        rsp_data_d = rsp_data_q;
        pprot_d    = pprot_q;
        paddr_d    = paddr_q;
        pstrb_d    = pstrb_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_vld) begin
                    pprot_d  = bus.req_prot;
                    paddr_d  = bus.req_addr;
                    pstrb_d  = bus.req_read ? '0 : bus.req_mask;
                    pwdata_d = bus.req_read ? '0 : bus.req_data;
                    pwrite_d = ~bus.req_read;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // pready has priority over a timeout landing in the same cycle
                if (bus.apb_pready) begin
                    rsp_excp_d = bus.apb_pslverr;
                    rsp_data_d = pwrite_q ? '0 : bus.apb_prdata;
                    state_d    = S_RESP;
                end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
                    rsp_excp_d = 1'b1;
                    rsp_data_d = '0;
                    state_d    = S_RESP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_rdy_d = (state_d == S_IDLE);
        rsp_vld_d = (state_d == S_RESP);
        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
    end

    // State and output registers; reset drops the bus immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_rdy_q  <= 1'b1;
            rsp_vld_q  <= 1'b0;
            rsp_excp_q <= 1'b0;
            rsp_data_q <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pprot_q    <= '0;
            paddr_q    <= '0;
            pstrb_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_rdy_q  <= req_rdy_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_excp_q <= rsp_excp_d;
            rsp_data_q <= rsp_data_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pprot_q    <= pprot_d;
            paddr_q    <= paddr_d;
            pstrb_q    <= pstrb_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
        end
    end

    assign bus.req_rdy     = req_rdy_q;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_excp    = rsp_excp_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.apb_psel    = psel_q;
    assign bus.apb_penable = penable_q;
    assign bus.apb_pprot   = pprot_q;
    assign bus.apb_paddr   = paddr_q;
    assign bus.apb_pstrb   = pstrb_q;
    assign bus.apb_pwrite  = pwrite_q;
    assign bus.apb_pwdata  = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_uv_apb_initiator.sv
//------------------------------------------------------------------------------
// Module      : tb_uv_apb_initiator
// Description : Directed self-checking bench for uv_apb_initiator with a small
//               configurable APB responder (wait states, error, read data).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uv_apb_initiator;

    localparam int ALEN    = 12;
    localparam int DLEN    = 32;
    localparam int MLEN    = 4;
    localparam int TMO_CYC = 8;

    logic clk = 1'b0;
    logic rst_n;

    uv_apb_initiator_if #(.ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN)) bus ();

    uv_apb_initiator #(
        .ALEN    (ALEN),
        .DLEN    (DLEN),
        .MLEN    (MLEN),
        .TMO_CYC (TMO_CYC)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Responder configuration
    int              wait_cfg  = 0;
    logic            err_cfg   = 1'b0;
    logic [DLEN-1:0] rdata_cfg = '0;
    int              wcnt      = 0;

    assign bus.apb_pready  = bus.apb_psel & bus.apb_penable & (wcnt == wait_cfg);
    assign bus.apb_pslverr = err_cfg;
    assign bus.apb_prdata  = rdata_cfg;

    // Responder wait-state counter: counts low-pready access cycles
    always @(posedge clk) begin
        if (bus.apb_psel && bus.apb_penable && !bus.apb_pready)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer from IDLE; optionally stalls the response for 'hold'
    // cycles while a further request is left pending.
    task automatic xfer(input string nm, input logic rd, input logic [ALEN-1:0] addr,
                        input logic [DLEN-1:0] data, input logic [MLEN-1:0] mask,
                        input logic [2:0] prot, input int exp_acc, input logic exp_excp,
                        input logic [DLEN-1:0] exp_data, input int hold);
        int acc;
        bus.req_vld  = 1'b1;
        bus.req_read = rd;
        bus.req_addr = addr;
        bus.req_data = data;
        bus.req_mask = mask;
        bus.req_prot = prot;
        bus.rsp_rdy  = 1'b1;
        check({nm, ".idle_rdy"}, bus.req_rdy, 1);
        tick();
        bus.req_vld = 1'b0;
        check({nm, ".setup_psel"},  bus.apb_psel, 1);
        check({nm, ".setup_pen"},   bus.apb_penable, 0);
        check({nm, ".setup_rdy"},   bus.req_rdy, 0);
        check({nm, ".paddr"},       bus.apb_paddr, addr);
        check({nm, ".pwrite"},      bus.apb_pwrite, !rd);
        check({nm, ".pstrb"},       bus.apb_pstrb, rd ? 0 : mask);
        check({nm, ".pwdata"},      bus.apb_pwdata, rd ? 0 : data);
        check({nm, ".pprot"},       bus.apb_pprot, prot);
        tick();
        acc = 0;
        while (bus.apb_penable && acc < 40) begin
            acc++;
            check({nm, ".acc_psel"}, bus.apb_psel, 1);
            tick();
        end
        check({nm, ".acc_cycles"}, acc, exp_acc);
        check({nm, ".rsp_vld"},    bus.rsp_vld, 1);
        check({nm, ".rsp_psel"},   bus.apb_psel, 0);
        check({nm, ".rsp_excp"},   bus.rsp_excp, exp_excp);
        check({nm, ".rsp_data"},   bus.rsp_data, exp_data);
        check({nm, ".rsp_rdy0"},   bus.req_rdy, 0);
        if (hold > 0) begin
            bus.rsp_rdy = 1'b0;
            bus.req_vld = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                check({nm, ".hold_vld"},  bus.rsp_vld, 1);
                check({nm, ".hold_data"}, bus.rsp_data, exp_data);
                check({nm, ".hold_excp"}, bus.rsp_excp, exp_excp);
                check({nm, ".hold_rdy"},  bus.req_rdy, 0);
            end
            bus.rsp_rdy = 1'b1;
        end
        tick();
        check({nm, ".done_rdy"},  bus.req_rdy, 1);
        check({nm, ".done_vld"},  bus.rsp_vld, 0);
        check({nm, ".done_psel"}, bus.apb_psel, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.req_vld  = 1'b0;
        bus.req_read = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_mask = '0;
        bus.req_prot = '0;
        bus.rsp_rdy  = 1'b1;
        repeat (2) tick();

        check("rst.req_rdy",  bus.req_rdy, 1);
        check("rst.rsp_vld",  bus.rsp_vld, 0);
        check("rst.rsp_excp", bus.rsp_excp, 0);
        check("rst.rsp_data", bus.rsp_data, 0);
        check("rst.psel",     bus.apb_psel, 0);
        check("rst.penable",  bus.apb_penable, 0);
        check("rst.pwrite",   bus.apb_pwrite, 0);
        check("rst.paddr",    bus.apb_paddr, 0);
        check("rst.pstrb",    bus.apb_pstrb, 0);
        check("rst.pwdata",   bus.apb_pwdata, 0);
        check("rst.pprot",    bus.apb_pprot, 0);
        rst_n = 1'b1;
        tick();

        // Zero-wait write
        wait_cfg = 0; err_cfg = 1'b0; rdata_cfg = 32'hFFFF_FFFF;
        xfer("wr0", 1'b0, 12'h000, 32'h00A5_0003, 4'hF, 3'b010, 1, 1'b0, 32'h0, 0);

        // Read with two wait states
        wait_cfg = 2; rdata_cfg = 32'h0000_0008;
        xfer("rd_w2", 1'b1, 12'h004, 32'h1234_5678, 4'hF, 3'b001, 3, 1'b0, 32'h8, 0);

        // Read with slave error
        wait_cfg = 0; err_cfg = 1'b1; rdata_cfg = 32'hDEAD_BEEF;
        xfer("rd_err", 1'b1, 12'h040, 32'h0, 4'h3, 3'b000, 1, 1'b1, 32'hDEAD_BEEF, 0);

        // Timeout: responder never ready
        wait_cfg = 1000; err_cfg = 1'b0; rdata_cfg = 32'h0000_1234;
        xfer("tmo", 1'b1, 12'h0FC, 32'h0, 4'h0, 3'b100, 8, 1'b1, 32'h0, 0);

        // pready on the last timeout cycle wins
        wait_cfg = 7; rdata_cfg = 32'h0000_55AA;
        xfer("tmo_edge", 1'b1, 12'h008, 32'h0, 4'h0, 3'b000, 8, 1'b0, 32'h55AA, 0);

        // Odd address and partial mask write, response held 5 cycles with a
        // request pending; the next transfer's SETUP follows 2 cycles later
        wait_cfg = 0; rdata_cfg = 32'h0;
        xfer("wr_hold", 1'b0, 12'h013, 32'hCAFE_F00D, 4'h6, 3'b011, 1, 1'b0, 32'h0, 5);
        rdata_cfg = 32'h0000_0077;
        xfer("rd_after", 1'b1, 12'h00C, 32'h0, 4'hF, 3'b000, 1, 1'b0, 32'h77, 0);

        // Reset during ACCESS
        wait_cfg = 1000;
        bus.req_vld  = 1'b1;
        bus.req_read = 1'b1;
        bus.req_addr = 12'h010;
        tick();
        bus.req_vld = 1'b0;
        tick();
        check("mrst.in_access", bus.apb_penable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst.psel",    bus.apb_psel, 0);
        check("mrst.penable", bus.apb_penable, 0);
        check("mrst.rsp_vld", bus.rsp_vld, 0);
        check("mrst.req_rdy", bus.req_rdy, 1);
        tick();
        rst_n = 1'b1;
        tick();
        wait_cfg = 1; err_cfg = 1'b0; rdata_cfg = 32'h0BAD_C0DE;
        xfer("post_rst", 1'b1, 12'h020, 32'h0, 4'hF, 3'b000, 2, 1'b0, 32'h0BAD_C0DE, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
